// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing constants and sprite defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // 640x480 @ 60 Hz reference timing
    localparam int c_hor_total_time  = 800;
    localparam int c_hor_blank_start = 640;
    localparam int c_hor_sync_start  = 656;
    localparam int c_hor_sync_time   = 96;
    localparam int c_ver_total_time  = 525;
    localparam int c_ver_blank_start = 480;
    localparam int c_ver_sync_start  = 490;
    localparam int c_ver_sync_time   = 2;

    // Stream field widths
    localparam int c_cnt_w = 11;
    localparam int c_rgb_w = 12;

    // Sprite image defaults
    localparam int         c_sprite_w         = 48;
    localparam int         c_sprite_h         = 64;
    localparam logic [11:0] c_sprite_transp_key = 12'h000;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA timing + colour stream bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_if;

    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay
//  Description : DEPTH-stage register delay for one VGA bundle plus one
//                sideband bit; every field sees identical latency.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    vga_if.in    in,
    vga_if.out   out,
    input  logic side_in,
    output logic side_out
);

    localparam int c_w = 2 * 11 + 4 + 12 + 1;

    logic [c_w-1:0] r_pipe [DEPTH];
    logic [c_w-1:0] w_head;

    assign w_head = {side_in, in.vcount, in.vsync, in.vblnk,
                     in.hcount, in.hsync, in.hblnk, in.rgb};

    // Shift the packed bundle one stage per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_head;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {side_out, out.vcount, out.vsync, out.vblnk,
            out.hcount, out.hsync, out.hblnk, out.rgb} = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : draw_sprite
//  Description : Composites a ROM-backed, optionally magnified sprite onto a
//                VGA stream. Position/enable are latched at frame start.
//  Revision    : 1.0  initial release
// ============================================================================
module draw_sprite
    import vga_pkg::*;
#(
    parameter int          IMG_W      = c_sprite_w,
    parameter int          IMG_H      = c_sprite_h,
    parameter int          ROM_LAT    = 1,
    parameter int          SCALE_LOG2 = 0,
    parameter int          TRANSP_EN  = 1,
    parameter logic [11:0] TRANSP_KEY = c_sprite_transp_key,
    localparam int         ADDR_W     = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic [11:0]       rgb_pixel,
    output logic [ADDR_W-1:0] pixel_addr,
    vga_if.in                 in,
    vga_if.out                out
);

    localparam logic [12:0] c_sw = 13'(IMG_W << SCALE_LOG2);
    localparam logic [12:0] c_sh = 13'(IMG_H << SCALE_LOG2);

    logic [11:0]       r_xpos_l;
    logic [11:0]       r_ypos_l;
    logic              r_en_l;

    logic              w_frame_start;
    logic [11:0]       w_xpos;
    logic [11:0]       w_ypos;
    logic              w_en;
    logic [12:0]       w_h13, w_v13, w_x13, w_y13;
    logic [12:0]       w_dx, w_dy, w_col, w_row;
    logic              w_hit;
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit_d;
    logic              w_key;

    vga_if dly ();

    // The capture pixel itself already uses the freshly presented values so
    // the whole frame, including pixel (0,0), is drawn from one position.
    assign w_frame_start = (in.vcount == 11'd0) && (in.hcount == 11'd0);
    assign w_xpos = w_frame_start ? xpos : r_xpos_l;
    assign w_ypos = w_frame_start ? ypos : r_ypos_l;
    assign w_en   = w_frame_start ? en   : r_en_l;

    // 13-bit arithmetic keeps xpos+SW from wrapping near the 4096 edge
    assign w_h13 = {2'b00, in.hcount};
    assign w_v13 = {2'b00, in.vcount};
    assign w_x13 = {1'b0, w_xpos};
    assign w_y13 = {1'b0, w_ypos};

    assign w_hit = w_en
                && (w_h13 >= w_x13) && (w_h13 < w_x13 + c_sw)
                && (w_v13 >= w_y13) && (w_v13 < w_y13 + c_sh);

    assign w_dx  = w_h13 - w_x13;
    assign w_dy  = w_v13 - w_y13;
    assign w_col = w_dx >> SCALE_LOG2;
    assign w_row = w_dy >> SCALE_LOG2;

    // Constant-coefficient multiply; row < IMG_H so the result fits ADDR_W
    assign w_addr = ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col);

    // Latch sprite position and enable once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xpos_l <= '0;
            r_ypos_l <= '0;
            r_en_l   <= 1'b0;
        end else if (w_frame_start) begin
            r_xpos_l <= xpos;
            r_ypos_l <= ypos;
            r_en_l   <= en;
        end
    end

    // Register the ROM address (zero outside the sprite)
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
        end else begin
            pixel_addr <= w_hit ? w_addr : '0;
        end
    end

    vga_delay #(
        .DEPTH (ROM_LAT + 1)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .out      (dly),
        .side_in  (w_hit),
        .side_out (w_hit_d)
    );

    assign w_key = (TRANSP_EN != 0) && (rgb_pixel == TRANSP_KEY);

    // Output register: overlay the ROM colour where the sprite is opaque
    always_ff @(posedge clk) begin
        if (rst) begin
            out.vcount <= '0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= '0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= dly.vcount;
            out.vsync  <= dly.vsync;
            out.vblnk  <= dly.vblnk;
            out.hcount <= dly.hcount;
            out.hsync  <= dly.hsync;
            out.hblnk  <= dly.hblnk;
            out.rgb    <= (w_hit_d && !w_key) ? rgb_pixel : dly.rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_draw_sprite
//  Description : Self-checking bench for draw_sprite: five instances share
//                one raster stream; a per-instance queue holds the expected
//                output and a spot table holds hand-derived pixel values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_draw_sprite;

    localparam int N     = 5;
    localparam int H_TOT = 648;
    localparam int V_TOT = 56;
    localparam int c_lat [N] = '{1, 3, 1, 1, 1};
    localparam int c_sc  [N] = '{0, 0, 1, 0, 0};

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        vblnk;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vid_t;

    typedef struct {
        bit   ok;
        int   fr;
        int   v;
        int   h;
        vid_t exp;
    } rec_t;

    typedef struct {
        int          inst;
        int          fr;
        int          v;
        int          h;
        bit          use_in;
        logic [11:0] rgb;
    } spot_t;

    logic        clk = 1'b0;
    logic        rst_v   [N];
    logic        en_v    [N];
    logic [11:0] xp      [N];
    logic [11:0] yp      [N];
    logic [11:0] rom_rgb [N];
    logic [11:0] paddr   [N];
    logic [11:0] rp      [N][4];
    vid_t        got     [N];

    rec_t  q [N][$];
    spot_t tbl [$];

    int m_x [N];
    int m_y [N];
    int m_en [N];

    int checks   = 0;
    int failures = 0;
    int prev_fr  = -1;
    int prev_v   = -1;
    int prev_h   = -1;
    bit prev_rst_e = 1'b0;

    always #5 clk = ~clk;

    vga_if vin ();
    vga_if vo0 ();
    vga_if vo1 ();
    vga_if vo2 ();
    vga_if vo3 ();
    vga_if vo4 ();

    draw_sprite #(.ROM_LAT(1), .SCALE_LOG2(0)) u_a (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .xpos(xp[0]), .ypos(yp[0]),
        .rgb_pixel(rom_rgb[0]), .pixel_addr(paddr[0]), .in(vin), .out(vo0));
    draw_sprite #(.ROM_LAT(3), .SCALE_LOG2(0)) u_b (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .xpos(xp[1]), .ypos(yp[1]),
        .rgb_pixel(rom_rgb[1]), .pixel_addr(paddr[1]), .in(vin), .out(vo1));
    draw_sprite #(.ROM_LAT(1), .SCALE_LOG2(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .xpos(xp[2]), .ypos(yp[2]),
        .rgb_pixel(rom_rgb[2]), .pixel_addr(paddr[2]), .in(vin), .out(vo2));
    draw_sprite #(.ROM_LAT(1), .SCALE_LOG2(0)) u_d (
        .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .xpos(xp[3]), .ypos(yp[3]),
        .rgb_pixel(rom_rgb[3]), .pixel_addr(paddr[3]), .in(vin), .out(vo3));
    draw_sprite #(.ROM_LAT(1), .SCALE_LOG2(0)) u_e (
        .clk(clk), .rst(rst_v[4]), .en(en_v[4]), .xpos(xp[4]), .ypos(yp[4]),
        .rgb_pixel(rom_rgb[4]), .pixel_addr(paddr[4]), .in(vin), .out(vo4));

    assign got[0] = {vo0.vcount, vo0.hcount, vo0.vsync, vo0.vblnk, vo0.hsync, vo0.hblnk, vo0.rgb};
    assign got[1] = {vo1.vcount, vo1.hcount, vo1.vsync, vo1.vblnk, vo1.hsync, vo1.hblnk, vo1.rgb};
    assign got[2] = {vo2.vcount, vo2.hcount, vo2.vsync, vo2.vblnk, vo2.hsync, vo2.hblnk, vo2.rgb};
    assign got[3] = {vo3.vcount, vo3.hcount, vo3.vsync, vo3.vblnk, vo3.hsync, vo3.hblnk, vo3.rgb};
    assign got[4] = {vo4.vcount, vo4.hcount, vo4.vsync, vo4.vblnk, vo4.hsync, vo4.hblnk, vo4.rgb};

    // Image ROM model: data = address, delivered ROM_LAT clocks later
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            rp[i][0] <= paddr[i];
            for (int j = 1; j < 4; j++) rp[i][j] <= rp[i][j-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) rom_rgb[i] = rp[i][c_lat[i]-1];
    end

    function automatic logic [11:0] inrgb(input int h, input int v);
        logic [10:0] hh;
        logic [10:0] vv;
        hh = 11'(h);
        vv = 11'(v);
        return {hh[5:0], vv[5:0]};
    endfunction

    function automatic logic [11:0] model_rgb(input int i, input int h, input int v);
        int sc;
        int dx;
        int dy;
        int a;
        logic [11:0] pix;
        sc = c_sc[i];
        dx = h - m_x[i];
        dy = v - m_y[i];
        if (m_en[i] != 0 && dx >= 0 && dx < (48 << sc) && dy >= 0 && dy < (64 << sc)) begin
            a   = (dy >> sc) * 48 + (dx >> sc);
            pix = a[11:0];
            if (pix != 12'h000) return pix;
        end
        return inrgb(h, v);
    endfunction

    task automatic add(input int inst, input int fr, input int v, input int h,
                       input bit use_in, input logic [11:0] rgb);
        spot_t s;
        s.inst = inst; s.fr = fr; s.v = v; s.h = h; s.use_in = use_in; s.rgb = rgb;
        tbl.push_back(s);
    endtask

    task automatic chk_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_rec(input int i, input rec_t e);
        logic [11:0] want;
        checks++;
        if (got[i] !== e.exp) begin
            failures++;
            $display("FAIL stream inst=%0d f=%0d v=%0d h=%0d got=%h expected=%h",
                     i, e.fr, e.v, e.h, got[i], e.exp);
        end
        if (e.ok) begin
            for (int k = 0; k < tbl.size(); k++) begin
                if (tbl[k].inst == i && tbl[k].fr == e.fr && tbl[k].v == e.v && tbl[k].h == e.h) begin
                    want = tbl[k].use_in ? inrgb(e.h, e.v) : tbl[k].rgb;
                    checks++;
                    if (got[i].rgb !== want) begin
                        failures++;
                        $display("FAIL spot inst=%0d f=%0d v=%0d h=%0d rgb got=%h expected=%h",
                                 i, e.fr, e.v, e.h, got[i].rgb, want);
                    end
                end
            end
        end
    endtask

    // One raster cycle: compare what leaves the DUTs, then drive and model
    task automatic cycle(input int fr, input int v, input int h, input bit r_all, input bit r_e);
        rec_t e;
        rec_t z;
        logic vs, vb, hs, hb;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() == c_lat[i] + 2) begin
                e = q[i].pop_front();
                check_rec(i, e);
            end
        end
        if (prev_fr == 0 && prev_v == 51 && prev_h == 110) begin
            chk_val("addr_a_51_110", int'(paddr[0]), 58);
            chk_val("addr_b_51_110", int'(paddr[1]), 58);
            chk_val("addr_d_51_110", int'(paddr[3]), 0);
        end
        if (prev_rst_e) begin
            chk_val("rst_e_out_zero", int'(got[4] != '0), 0);
            chk_val("rst_e_addr_zero", int'(paddr[4]), 0);
        end

        if (fr == 0 && v == 20 && h == 0) xp[4] = 12'd300;
        for (int i = 0; i < N; i++) rst_v[i] = r_all || (i == 4 && r_e);

        hb = (h >= 640);
        hs = (h >= 642 && h < 646);
        vb = (v >= 48);
        vs = (v >= 50 && v < 52);
        vin.vcount = 11'(v);
        vin.hcount = 11'(h);
        vin.vblnk  = vb;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.hsync  = hs;
        vin.rgb    = inrgb(h, v);

        z.ok = 1'b0; z.fr = -1; z.v = 0; z.h = 0; z.exp = '0;
        for (int i = 0; i < N; i++) begin
            if (rst_v[i]) begin
                for (int k = 0; k < q[i].size(); k++) q[i][k] = z;
                q[i].push_back(z);
                m_x[i] = 0; m_y[i] = 0; m_en[i] = 0;
            end else begin
                if (v == 0 && h == 0) begin
                    m_x[i]  = int'(xp[i]);
                    m_y[i]  = int'(yp[i]);
                    m_en[i] = int'(en_v[i]);
                end
                e.ok = 1'b1; e.fr = fr; e.v = v; e.h = h;
                e.exp = {11'(v), 11'(h), vs, vb, hs, hb, model_rgb(i, h, v)};
                q[i].push_back(e);
            end
        end
        prev_fr = fr; prev_v = v; prev_h = h; prev_rst_e = r_e;
    endtask

    initial begin
        bit stop;
        int vmax;
        bit re;

        // inst, frame, vcount, hcount, pass-through?, rom colour
        add(0, 0, 50, 100, 1, 12'h000);  add(0, 0, 50, 101, 0, 12'h001);
        add(0, 0, 50, 147, 0, 12'h02F);  add(0, 0, 50, 148, 1, 12'h000);
        add(0, 0, 51, 100, 0, 12'h030);  add(0, 0, 49, 100, 1, 12'h000);
        add(1, 0, 50, 100, 1, 12'h000);  add(1, 0, 50, 101, 0, 12'h001);
        add(1, 0, 50, 147, 0, 12'h02F);  add(1, 0, 50, 148, 1, 12'h000);
        add(1, 0, 51, 100, 0, 12'h030);  add(1, 0, 49, 100, 1, 12'h000);
        add(2, 0, 0, 0, 1, 12'h000);     add(2, 0, 0, 1, 1, 12'h000);
        add(2, 0, 1, 0, 1, 12'h000);     add(2, 0, 1, 1, 1, 12'h000);
        add(2, 0, 0, 2, 0, 12'h001);     add(2, 0, 2, 0, 0, 12'h030);
        add(2, 0, 0, 95, 0, 12'h02F);    add(2, 0, 0, 96, 1, 12'h000);
        add(2, 0, 2, 95, 0, 12'h05F);    add(2, 0, 3, 2, 0, 12'h031);
        add(3, 0, 0, 619, 1, 12'h000);   add(3, 0, 0, 620, 1, 12'h000);
        add(3, 0, 0, 621, 0, 12'h001);   add(3, 0, 0, 639, 0, 12'h013);
        add(3, 0, 1, 620, 0, 12'h030);   add(3, 0, 0, 10, 1, 12'h000);
        add(3, 0, 3, 0, 1, 12'h000);
        add(4, 0, 25, 101, 0, 12'h4B1);  add(4, 0, 25, 301, 1, 12'h000);
        add(4, 1, 10, 301, 0, 12'h1E1);  add(4, 1, 10, 101, 1, 12'h000);
        add(4, 1, 29, 305, 0, 12'h575);  add(4, 1, 40, 301, 1, 12'h000);
        add(4, 2, 2, 301, 0, 12'h061);   add(4, 2, 0, 300, 1, 12'h000);
        add(4, 2, 1, 347, 0, 12'h05F);

        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b1;
            en_v[i]  = 1'b1;
            m_x[i] = 0; m_y[i] = 0; m_en[i] = 0;
        end
        xp[0] = 12'd100; yp[0] = 12'd50;
        xp[1] = 12'd100; yp[1] = 12'd50;
        xp[2] = 12'd0;   yp[2] = 12'd0;
        xp[3] = 12'd620; yp[3] = 12'd0;
        xp[4] = 12'd100; yp[4] = 12'd0;
        vin.vcount = '0; vin.hcount = '0; vin.vsync = 1'b0; vin.vblnk = 1'b0;
        vin.hsync = 1'b0; vin.hblnk = 1'b0; vin.rgb = 12'hABC;

        for (int k = 0; k < 4; k++) cycle(-1, 55, 640 + k, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk_val($sformatf("reset_out_%0d", i), int'(got[i] != '0), 0);
            chk_val($sformatf("reset_addr_%0d", i), int'(paddr[i]), 0);
        end

        stop = 1'b0;
        for (int fr = 0; fr < 3 && !stop; fr++) begin
            vmax = (fr == 2) ? 6 : V_TOT;
            for (int v = 0; v < vmax && !stop; v++) begin
                for (int h = 0; h < H_TOT && !stop; h++) begin
                    re = (fr == 1 && v == 30 && h == 310);
                    cycle(fr, v, h, 1'b0, re);
                    if (failures > 200) stop = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
